sign_mag_rom_arbiter: RTL
=========================

Name: sign_mag_rom_arbiter

Overview:
Round-robin arbiter and sequencer that shares one synchronous sign-magnitude adder ROM among NUM_REQ requesters. Each requester presents two sign-magnitude operands with a valid/ready handshake. The arbiter grants at most one request per cycle and drives the ROM address operands. It tags each issued lookup and returns the ROM result to the originating requester after ROM_LATENCY cycles. It sits between the client blocks and a single sign_mag_rom instance, which is instantiated outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OP_WIDTH, 4, sign-magnitude operand/result width (MSB = sign); ROM address = 2*OP_WIDTH
ROM_LATENCY, 1, clock cycles from ROM operands driven to rom_r_data valid (1..3)
CNT_WIDTH, 16, width of transaction counter

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
en  input  1  1 = grants allowed; 0 = no new grants, in-flight lookups complete
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant (one-hot or zero)
req_a  input  NUM_REQ*OP_WIDTH  packed operand A, slice i = requester i
req_b  input  NUM_REQ*OP_WIDTH  packed operand B, slice i = requester i
rom_input1  output  OP_WIDTH  to ROM input1 (operand A of granted requester)
rom_input2  output  OP_WIDTH  to ROM input2 (operand B of granted requester)
rom_r_data  input  OP_WIDTH  ROM read data
rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle
rsp_id  output  $clog2(NUM_REQ)  requester index of current response
rsp_data  output  OP_WIDTH  sign-magnitude sum; valid only while rsp_valid != 0
txn_count  output  CNT_WIDTH  number of accepted requests since reset

Behaviour:
- Reset (async, reset_n=0):
  - rr_ptr=0; tag pipeline cleared; rsp_valid=0; rsp_id=0; txn_count=0; req_ready=0.
  - Reset takes effect immediately regardless of clk.
  - Lookups in flight are dropped; no response is emitted for them after reset releases.
- Arbitration is combinational in each cycle:
  - If en=1 and any req_valid is set, grant the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 only for the granted index g. All other bits are 0.
  - If en=0 or no valid request, req_ready=0.
- Transfer occurs when req_valid[i] & req_ready[i].
  - Requester must hold req_a/req_b stable and req_valid high until its transfer.
  - Deasserting req_valid before the transfer is allowed; nothing is issued.
- rom_input1/rom_input2 = operands of the granted requester, combinationally.
  - With no grant, they hold the operands of requester rr_ptr. The value is don't-care but must be deterministic.
- On the transfer edge:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - txn_count increments, wrapping at 2^CNT_WIDTH-1 -> 0.
  - {valid=1, id=g} enters a ROM_LATENCY-deep tag shift register.
- With no transfer, rr_ptr holds and a bubble (valid=0) enters the pipeline.
- Response timing:
  - A request transferred in cycle k produces rsp_valid[g]=1, rsp_id=g, rsp_data=rom_r_data in cycle k+ROM_LATENCY, for exactly one cycle.
  - rsp_data is passthrough of rom_r_data; rsp_valid/rsp_id come from the tag pipeline output.
- Throughput is one lookup per cycle, fully pipelined. Back-to-back grants to different requesters yield back-to-back responses in grant order.
- Responses have no backpressure; requesters must accept the response in the cycle it is strobed.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0...
  - No requester waits more than NUM_REQ-1 cycles once valid, while en=1.
- Single requester continuously valid: granted every cycle.
- en deasserted mid-stream:
  - Grants stop in that same cycle.
  - Already-issued lookups still respond on schedule.
  - rr_ptr is preserved.
- Simultaneous transfer and response in the same cycle is normal pipeline operation; both proceed independently.
- The arbiter does not interpret the sign-magnitude data. It only routes operands and results; the arithmetic is defined entirely by ROM contents.

Test Plan:
- Reset check: reset_n=0 with random inputs -> req_ready=0, rsp_valid=0, txn_count=0. Assert reset_n=0 between edges -> outputs clear without waiting for a clock.
- Single lookup, ROM_LATENCY=1: req_valid=0001, a=0011 (+3), b=0010 (+2) -> req_ready=0001 in the same cycle; next cycle rsp_valid=0001, rsp_id=0, rsp_data=0101 (+5); txn_count=1.
- Mixed signs: requester 2, a=1011 (-3), b=0010 (+2) -> rsp_valid=0100, rsp_id=2, rsp_data=1001 (-1), ROM_LATENCY cycles after transfer.
- Round-robin: req_valid=1111 held for 8 cycles with distinct operands -> grant order 0,1,2,3,0,1,2,3; responses in the same order, each with the correct sum; txn_count=8.
- Gating: en=0 while req_valid=0110 -> req_ready=0 and no new rsp_valid. The response for a request issued in the cycle before en fell still arrives. On en=1, the grant resumes at the preserved rr_ptr.
- Reset mid-flight, ROM_LATENCY=3: issue 2 requests, pulse reset_n low before their responses are due -> no rsp_valid ever appears for them; rr_ptr=0 after release.

Source files
------------

// File: rtl/sign_mag_rom_arbiter_if.sv
// Requester/ROM bus between the client blocks, the shared sign-magnitude ROM and the arbiter.
// slave is the arbiter's view; master is the client/ROM view.
`timescale 1ns/1ps
interface sign_mag_rom_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned OP_WIDTH = 4
);
  localparam int unsigned IdWidth = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*OP_WIDTH-1:0] req_a;
  logic [NUM_REQ*OP_WIDTH-1:0] req_b;
  logic [OP_WIDTH-1:0]         rom_input1;
  logic [OP_WIDTH-1:0]         rom_input2;
  logic [OP_WIDTH-1:0]         rom_r_data;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [IdWidth-1:0]          rsp_id;
  logic [OP_WIDTH-1:0]         rsp_data;

  modport slave (
    input  req_valid, req_a, req_b, rom_r_data,
    output req_ready, rom_input1, rom_input2, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, rom_r_data,
    input  req_ready, rom_input1, rom_input2, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/sign_mag_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sign-magnitude adder ROM among NUM_REQ
// requesters. Grants at most one lookup per cycle and routes each result back to its
// requester ROM_LATENCY cycles later via a tag pipeline.
`timescale 1ns/1ps
module sign_mag_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned OP_WIDTH    = 4,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  sign_mag_rom_arbiter_if.slave bus,
  output logic [CNT_WIDTH-1:0] txn_count
);

  localparam int unsigned  PtrW    = $clog2(NUM_REQ);
  localparam logic [PtrW:0] NumReqW = (PtrW + 1)'(NUM_REQ);

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  logic                 found;
  logic [PtrW-1:0]      offset;
  logic [PtrW:0]        gnt_sum;
  logic [PtrW:0]        ptr_inc;
  logic [PtrW-1:0]      gnt_idx;
  logic                 gnt_valid;
  logic [PtrW-1:0]      sel;
  logic                 xfer;

  logic [ROM_LATENCY-1:0]           tag_vld_q;
  logic [ROM_LATENCY-1:0][PtrW-1:0] tag_id_q;
  logic [CNT_WIDTH-1:0]             txn_count_q;

  // Rotate valids so rr_ptr sits at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    dbl_valid = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
    rot_valid = dbl_valid[NUM_REQ-1:0];
    found     = 1'b0;
    offset    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        found  = 1'b1;
        offset = PtrW'(i);
      end
    end
    gnt_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    if (gnt_sum >= NumReqW) begin
      gnt_sum = gnt_sum - NumReqW;
    end
    gnt_idx = gnt_sum[PtrW-1:0];
    // Gating with reset_n keeps req_ready low while reset is held.
    gnt_valid = found & en & reset_n;
  end

  // One-hot ready and ROM operand mux; idle cycles present rr_ptr's operands.
  always_comb begin
    bus.req_ready  = '0;
    bus.rom_input1 = '0;
    bus.rom_input2 = '0;
    sel = gnt_valid ? gnt_idx : rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = gnt_valid && (gnt_idx == PtrW'(i));
      if (sel == PtrW'(i)) begin
        bus.rom_input1 = bus.req_a[i*OP_WIDTH +: OP_WIDTH];
        bus.rom_input2 = bus.req_b[i*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  // Pointer advances past the winner on a transfer, otherwise holds.
  always_comb begin
    xfer     = |(bus.req_valid & bus.req_ready);
    ptr_inc  = {1'b0, gnt_idx} + 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (ptr_inc == NumReqW) ? '0 : ptr_inc[PtrW-1:0];
    end
  end

  // Arbitration state, tag shift register and transaction counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      txn_count_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tag_vld_q[0] <= xfer;
      // Bubbles carry id 0 so rsp_id stays deterministic between responses.
      tag_id_q[0]  <= xfer ? gnt_idx : '0;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      if (xfer) begin
        txn_count_q <= txn_count_q + 1'b1;
      end
    end
  end

  // Response strobe decoded from the pipeline tail; data passes straight from the ROM.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = tag_vld_q[ROM_LATENCY-1] && (tag_id_q[ROM_LATENCY-1] == PtrW'(i));
    end
    bus.rsp_id   = tag_id_q[ROM_LATENCY-1];
    bus.rsp_data = bus.rom_r_data;
    txn_count    = txn_count_q;
  end

endmodule
